// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcodes, state and control encodings; TRAP state exists only with ILLEGAL_TRAP_EN
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_LBRD,
    S_LBWR,
    S_SBWR,
    S_RTYPEEX,
    S_RTYPEWR,
    S_IMMEX,
    S_IMMWR,
    S_BREX,
    S_JEX
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_IMM   = 2'b11
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_BEAT   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_TRAP   = 2'b11
  } pcsrc_t;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/mc_controller_p_if.sv
// rtl/mc_controller_p_if.sv - memory request/ready handshake between controller and memory
interface mc_controller_p_if;
  logic memread;
  logic memwrite;
  logic iord;
  logic mem_ready;

  modport master (output memread, output memwrite, output iord, input mem_ready);
  modport slave  (input memread, input memwrite, input iord, output mem_ready);
endinterface

// File: rtl/mc_beat_counter.sv
// rtl/mc_beat_counter.sv - fetch beat counter, advances on ready and wraps after the last beat
module mc_beat_counter #(
  parameter int  BEATS = 4,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output logic [CW-1:0] beat,
  output logic          last
);

  logic [CW-1:0] beat_q;

  // With a single beat the register is held at zero and last is always set.
  assign last = (beat_q == CW'(BEATS - 1));
  assign beat = beat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else if (advance) begin
      beat_q <= last ? '0 : beat_q + CW'(1);
    end
  end

endmodule

// File: rtl/mc_controller_p.sv
// rtl/mc_controller_p.sv - multicycle MIPS-subset control FSM with multi-beat fetch
// Optional illegal-opcode trap state enabled by ILLEGAL_TRAP_EN.
module mc_controller_p
  import mc_pkg::*;
#(
  parameter int  MEM_W = 8,
  localparam int BEATS = 32 / MEM_W,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic               zero,
  mc_controller_p_if.master  mem,
  output logic [BEATS-1:0]   irwrite,
  output logic               pchange,
  output logic               regwrite,
  output logic [1:0]         aluop,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsource,
  output logic               memtoreg,
  output logic               regdst,
  output logic               illegal
);

  state_t state, state_nxt;

  logic [CW-1:0]    beat;
  logic             last_beat;
  logic             fetch_adv;
  logic [BEATS-1:0] ir_onehot;

  logic             memread_d, memwrite_d, iord_d;
  logic [BEATS-1:0] irwrite_d;
  logic             pcwrite, pcwritecond, taken;
  logic             regwrite_d, alusrca_d, memtoreg_d, regdst_d;
  aluop_t           aluop_d;
  srcb_t            alusrcb_d;
  pcsrc_t           pcsource_d;
  logic             illegal_q;

  assign fetch_adv = (state == S_FETCH) && mem.mem_ready;

  mc_beat_counter #(.BEATS(BEATS)) u_beat (
    .clk     (clk),
    .rst_n   (reset_n),
    .advance (fetch_adv),
    .beat    (beat),
    .last    (last_beat)
  );

  // First beat lands in the most significant IR slice.
  assign ir_onehot = BEATS'(1) << (CW'(BEATS - 1) - beat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    memread_d   = 1'b0;
    memwrite_d  = 1'b0;
    iord_d      = 1'b0;
    irwrite_d   = '0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    regwrite_d  = 1'b0;
    alusrca_d   = 1'b0;
    memtoreg_d  = 1'b0;
    regdst_d    = 1'b0;
    aluop_d     = ALU_ADD;
    alusrcb_d   = SRCB_B;
    pcsource_d  = PC_ALU;
    case (state)
      S_FETCH: begin
        memread_d = 1'b1;
        alusrcb_d = SRCB_BEAT;
        if (mem.mem_ready) begin
          irwrite_d = ir_onehot;
          pcwrite   = 1'b1;
          if (last_beat) state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb_d = SRCB_IMM_SH;
        if (op == OP_LB || op == OP_SB)        state_nxt = S_MEMADR;
        else if (op == OP_RTYPE)               state_nxt = S_RTYPEEX;
        else if (op == OP_BEQ || op == OP_BNE) state_nxt = S_BREX;
        else if (op == OP_J)                   state_nxt = S_JEX;
        else if (is_imm_op(op))                state_nxt = S_IMMEX;
`ifdef ILLEGAL_TRAP_EN
        else                                   state_nxt = S_TRAP;
`else
        else                                   state_nxt = S_FETCH;
`endif
      end
      S_MEMADR: begin
        alusrca_d = 1'b1;
        alusrcb_d = SRCB_IMM;
        state_nxt = (op == OP_SB) ? S_SBWR : S_LBRD;
      end
      S_LBRD: begin
        memread_d = 1'b1;
        iord_d    = 1'b1;
        if (mem.mem_ready) state_nxt = S_LBWR;
      end
      S_LBWR: begin
        regwrite_d = 1'b1;
        memtoreg_d = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_SBWR: begin
        memwrite_d = 1'b1;
        iord_d     = 1'b1;
        if (mem.mem_ready) state_nxt = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca_d = 1'b1;
        aluop_d   = ALU_FUNCT;
        state_nxt = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        regwrite_d = 1'b1;
        regdst_d   = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_IMMEX: begin
        alusrca_d = 1'b1;
        alusrcb_d = SRCB_IMM;
        aluop_d   = ALU_IMM;
        state_nxt = S_IMMWR;
      end
      S_IMMWR: begin
        regwrite_d = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BREX: begin
        alusrca_d   = 1'b1;
        aluop_d     = ALU_SUB;
        pcsource_d  = PC_ALUOUT;
        pcwritecond = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_JEX: begin
        pcwrite    = 1'b1;
        pcsource_d = PC_JUMP;
        state_nxt  = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        pcwrite    = 1'b1;
        pcsource_d = PC_TRAP;
        state_nxt  = S_FETCH;
      end
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  assign taken = (op == OP_BNE) ? ~zero : zero;

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              illegal_q <= 1'b0;
    else if (state == S_TRAP)  illegal_q <= 1'b1;
  end
`else
  assign illegal_q = 1'b0;
`endif

  // All outputs are squashed while reset is held so an aborted access is dropped at once.
  assign mem.memread  = reset_n & memread_d;
  assign mem.memwrite = reset_n & memwrite_d;
  assign mem.iord     = reset_n & iord_d;
  assign irwrite      = irwrite_d & {BEATS{reset_n}};
  assign pchange      = reset_n & (pcwrite | (pcwritecond & taken));
  assign regwrite     = reset_n & regwrite_d;
  assign aluop        = aluop_d & {2{reset_n}};
  assign alusrca      = reset_n & alusrca_d;
  assign alusrcb      = alusrcb_d & {2{reset_n}};
  assign pcsource     = pcsource_d & {2{reset_n}};
  assign memtoreg     = reset_n & memtoreg_d;
  assign regdst       = reset_n & regdst_d;
  assign illegal      = reset_n & illegal_q;

endmodule

// File: tb/tb_mc_controller_p.sv
// tb/tb_mc_controller_p.sv - checks MEM_W 8/16/32 controllers against an instruction-schedule model
module tb_mc_controller_p;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic [3:0] irwrite;
    logic       pchange;
    logic       regwrite;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       illegal;
  } outs_t;

  localparam int K_FETCH = 0, K_DEC = 1, K_MEMADR = 2, K_LBRD = 3, K_LBWR = 4, K_SBWR = 5;
  localparam int K_REX = 6, K_RWR = 7, K_IMMEX = 8, K_IMMWR = 9, K_BR = 10, K_JEX = 11, K_TRAP = 12;

  localparam logic [5:0] T_R = 6'b000000, T_J = 6'b000010, T_BEQ = 6'b000100, T_BNE = 6'b000101;
  localparam logic [5:0] T_ADDI = 6'b001000, T_SLTI = 6'b001010, T_ANDI = 6'b001100;
  localparam logic [5:0] T_ORI = 6'b001101, T_LB = 6'b100000, T_SB = 6'b101000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op_v [3];
  logic       zero_v [3];
  logic       ready_v [3];

  logic [3:0] irw0;
  logic [1:0] irw1;
  logic       irw2;
  logic       pchange_o [3], regwrite_o [3], alusrca_o [3], memtoreg_o [3], regdst_o [3], illegal_o [3];
  logic [1:0] aluop_o [3], alusrcb_o [3], pcsource_o [3];
  outs_t      act [3];

  int   mq [3][$];
  logic ill_m [3];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mc_controller_p_if mif0 ();
  mc_controller_p_if mif1 ();
  mc_controller_p_if mif2 ();

  assign mif0.mem_ready = ready_v[0];
  assign mif1.mem_ready = ready_v[1];
  assign mif2.mem_ready = ready_v[2];

  mc_controller_p #(.MEM_W(8)) u_dut8 (
    .clk(clk), .reset_n(rst_n), .op(op_v[0]), .zero(zero_v[0]), .mem(mif0),
    .irwrite(irw0), .pchange(pchange_o[0]), .regwrite(regwrite_o[0]), .aluop(aluop_o[0]),
    .alusrca(alusrca_o[0]), .alusrcb(alusrcb_o[0]), .pcsource(pcsource_o[0]),
    .memtoreg(memtoreg_o[0]), .regdst(regdst_o[0]), .illegal(illegal_o[0])
  );

  mc_controller_p #(.MEM_W(16)) u_dut16 (
    .clk(clk), .reset_n(rst_n), .op(op_v[1]), .zero(zero_v[1]), .mem(mif1),
    .irwrite(irw1), .pchange(pchange_o[1]), .regwrite(regwrite_o[1]), .aluop(aluop_o[1]),
    .alusrca(alusrca_o[1]), .alusrcb(alusrcb_o[1]), .pcsource(pcsource_o[1]),
    .memtoreg(memtoreg_o[1]), .regdst(regdst_o[1]), .illegal(illegal_o[1])
  );

  mc_controller_p #(.MEM_W(32)) u_dut32 (
    .clk(clk), .reset_n(rst_n), .op(op_v[2]), .zero(zero_v[2]), .mem(mif2),
    .irwrite(irw2), .pchange(pchange_o[2]), .regwrite(regwrite_o[2]), .aluop(aluop_o[2]),
    .alusrca(alusrca_o[2]), .alusrcb(alusrcb_o[2]), .pcsource(pcsource_o[2]),
    .memtoreg(memtoreg_o[2]), .regdst(regdst_o[2]), .illegal(illegal_o[2])
  );

  assign act[0] = {mif0.memread, mif0.memwrite, irw0, pchange_o[0], regwrite_o[0], aluop_o[0],
                   alusrca_o[0], alusrcb_o[0], pcsource_o[0], mif0.iord, memtoreg_o[0],
                   regdst_o[0], illegal_o[0]};
  assign act[1] = {mif1.memread, mif1.memwrite, 2'b00, irw1, pchange_o[1], regwrite_o[1],
                   aluop_o[1], alusrca_o[1], alusrcb_o[1], pcsource_o[1], mif1.iord,
                   memtoreg_o[1], regdst_o[1], illegal_o[1]};
  assign act[2] = {mif2.memread, mif2.memwrite, 3'b000, irw2, pchange_o[2], regwrite_o[2],
                   aluop_o[2], alusrca_o[2], alusrcb_o[2], pcsource_o[2], mif2.iord,
                   memtoreg_o[2], regdst_o[2], illegal_o[2]};

  // Instruction schedule: BEATS fetch steps, decode, then the op's execution steps.
  function automatic void build(int k);
    int nb = 4 >> k;
    for (int b = 0; b < nb; b++) mq[k].push_back(K_FETCH * 16 + b);
    mq[k].push_back(K_DEC * 16);
    case (op_v[k])
      T_LB:                        begin mq[k].push_back(K_MEMADR * 16); mq[k].push_back(K_LBRD * 16); mq[k].push_back(K_LBWR * 16); end
      T_SB:                        begin mq[k].push_back(K_MEMADR * 16); mq[k].push_back(K_SBWR * 16); end
      T_R:                         begin mq[k].push_back(K_REX * 16); mq[k].push_back(K_RWR * 16); end
      T_BEQ, T_BNE:                mq[k].push_back(K_BR * 16);
      T_J:                         mq[k].push_back(K_JEX * 16);
      T_ADDI, T_ANDI, T_ORI, T_SLTI: begin mq[k].push_back(K_IMMEX * 16); mq[k].push_back(K_IMMWR * 16); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        mq[k].push_back(K_TRAP * 16);
`endif
      end
    endcase
  endfunction

  function automatic outs_t expect_out(int k, int step);
    outs_t e = '0;
    int kind = step / 16;
    int beat = step % 16;
    e.illegal = ill_m[k];
    case (kind)
      K_FETCH: begin
        e.memread = 1'b1;
        e.alusrcb = 2'b01;
        if (ready_v[k]) begin
          e.irwrite = 4'(1 << ((4 >> k) - 1 - beat));
          e.pchange = 1'b1;
        end
      end
      K_DEC:    e.alusrcb = 2'b11;
      K_MEMADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      K_LBRD:   begin e.memread = 1'b1; e.iord = 1'b1; end
      K_LBWR:   begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
      K_SBWR:   begin e.memwrite = 1'b1; e.iord = 1'b1; end
      K_REX:    begin e.alusrca = 1'b1; e.aluop = 2'b10; end
      K_RWR:    begin e.regwrite = 1'b1; e.regdst = 1'b1; end
      K_IMMEX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = 2'b11; end
      K_IMMWR:  e.regwrite = 1'b1;
      K_BR: begin
        e.alusrca  = 1'b1;
        e.aluop    = 2'b01;
        e.pcsource = 2'b01;
        e.pchange  = (op_v[k] == T_BEQ) ? zero_v[k] : ~zero_v[k];
      end
      K_JEX:    begin e.pchange = 1'b1; e.pcsource = 2'b10; end
      K_TRAP:   begin e.pchange = 1'b1; e.pcsource = 2'b11; end
      default:  e = '0;
    endcase
    if (!rst_n) e = '0;
    return e;
  endfunction

  task automatic sample();
    outs_t e;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (mq[k].size() == 0) build(k);
      e = expect_out(k, mq[k][0]);
      checks++;
      if (act[k] !== e) begin
        errors++;
        $display("FAIL model_k%0d t=%0t: got %h expected %h", k, $time, act[k], e);
      end
    end
  endtask

  task automatic adv();
    int kind;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mq[k].delete();
        ill_m[k] = 1'b0;
      end else begin
        kind = mq[k][0] / 16;
        if (!(kind inside {K_FETCH, K_LBRD, K_SBWR}) || ready_v[k]) begin
          if (kind == K_TRAP) ill_m[k] = 1'b1;
          void'(mq[k].pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [10] = '{T_R, T_J, T_BEQ, T_BNE, T_ADDI, T_SLTI, T_ANDI, T_ORI, T_LB, T_SB};
    int r = $urandom_range(0, 10);
    if (r == 10) return 6'($urandom);
    return tbl[r];
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      op_v[k] = T_ADDI;
      zero_v[k] = 1'b0;
      ready_v[k] = 1'b1;
      ill_m[k] = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sample();
    chk("reset_outputs_k0", 32'(act[0]), 0);
    adv();

    for (int c = 1; c <= 26; c++) begin
      rst_n      = (c != 22);
      ready_v[0] = 1'b1;
      ready_v[1] = (c > 3);
      ready_v[2] = !(c inside {13, 14, 20, 21});
      zero_v[2]  = (c == 3 || c == 9);
      op_v[2]    = (c <= 6) ? T_BNE : (c <= 9) ? T_BEQ : (c <= 16) ? T_LB : (c <= 22) ? T_SB : 6'b111111;
      sample();
      case (c)
        1: begin chk("k0_irwrite_b0", act[0].irwrite, 4'b1000); chk("k0_pchange_b0", act[0].pchange, 1); end
        2: chk("k0_irwrite_b1", act[0].irwrite, 4'b0100);
        3: begin chk("k0_irwrite_b2", act[0].irwrite, 4'b0010); chk("k2_bne_zero1_pchange", act[2].pchange, 0); end
        4: begin chk("k0_irwrite_b3", act[0].irwrite, 4'b0001); chk("k1_irwrite_ready", act[1].irwrite, 2); end
        5: begin chk("k0_decode_alusrcb", act[0].alusrcb, 3); chk("k1_irwrite_b1", act[1].irwrite, 1); end
        6: begin
          chk("k0_immex_aluop", act[0].aluop, 3);
          chk("k2_bne_zero0_pchange", act[2].pchange, 1);
          chk("k2_bne_pcsource", act[2].pcsource, 1);
        end
        7: begin chk("k0_immwr_regwrite", act[0].regwrite, 1); chk("k0_immwr_regdst", act[0].regdst, 0); end
        8: chk("k0_refetch_irwrite", act[0].irwrite, 4'b1000);
        9: chk("k2_beq_zero1_pchange", act[2].pchange, 1);
        13, 14, 15: begin chk("k2_lbrd_memread", act[2].memread, 1); chk("k2_lbrd_iord", act[2].iord, 1); end
        16: begin chk("k2_lbwr_regwrite", act[2].regwrite, 1); chk("k2_lbwr_memtoreg", act[2].memtoreg, 1); end
        20, 21: chk("k2_sbwr_memwrite", act[2].memwrite, 1);
        22: begin chk("k2_reset_in_sbwr", 32'(act[2]), 0); chk("k1_reset_outputs", 32'(act[1]), 0); end
        23: begin chk("k2_post_reset_memread", act[2].memread, 1); chk("k2_post_reset_irwrite", act[2].irwrite, 1); end
`ifdef ILLEGAL_TRAP_EN
        25: begin chk("k2_trap_pcsource", act[2].pcsource, 3); chk("k2_trap_pchange", act[2].pchange, 1); end
        26: chk("k2_illegal_set", act[2].illegal, 1);
`else
        25: begin chk("k2_illegal_refetch", act[2].memread, 1); chk("k2_illegal_off", act[2].illegal, 0); end
        26: chk("k2_illegal_off_later", act[2].illegal, 0);
`endif
        default: ;
      endcase
      adv();
    end

    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 3; k++) begin
        if (mq[k].size() == 0) op_v[k] = pick_op();
        ready_v[k] = ($urandom_range(0, 3) != 0);
        zero_v[k]  = 1'($urandom_range(0, 1));
      end
      sample();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
